// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer.
package core_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Program base addresses, indexed by slot number (slot 0 is the lowest element).
  localparam logic [3:0][7:0] PROG_BASE = {8'hC0, 8'h80, 8'h40, 8'h00};

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter with synchronous clear and enable that saturates at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_sequencer.sv
// Run controller for a small core: loads a program base, runs until halt,
// watchdog expiry or abort, and reports completion.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [8:0]  HALT_WORD      = 9'h1FF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  prog_sel,
  input  logic [8:0]  instr,
  output logic        pc_load,
  output logic [7:0]  pc_load_val,
  output logic        core_en,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        timeout_q, timeout_d;
  logic        halt;
  logic        expire;
  logic        cnt_clr;
  logic        cnt_en;

  assign halt   = (instr == HALT_WORD);
  assign expire = (cycle_count == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (!start) state_d = RUN;
      RUN: begin
        // Abort beats halt, halt beats watchdog.
        if (start) begin
          state_d = LOAD;
        end else if (halt) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    // Slot and watchdog flag are captured only on entry into LOAD.
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      sel_d     = prog_sel;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  // Clearing on the transition into LOAD makes the count read zero for the whole LOAD dwell.
  assign cnt_clr = (state_d == LOAD);
  assign cnt_en  = (state_q == RUN);

  sat_counter16 u_cycle_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycle_count)
  );

  assign pc_load     = (state_q == LOAD);
  assign pc_load_val = PROG_BASE[sel_q];
  assign core_en     = (state_q == RUN) && !halt;
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench with a scoreboard queue for core_sequencer.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic [8:0]  instr;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic        core_en;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  core_sequencer #(
    .HALT_WORD      (9'h1FF),
    .TIMEOUT_CYCLES (16'd16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (prog_sel),
    .instr       (instr),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .core_en     (core_en),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  typedef struct {
    string       name;
    logic [27:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [27:0] act;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic expect_out(input string nm, input logic pl, input logic [7:0] plv,
                            input logic ce, input logic dn, input logic to,
                            input logic [15:0] cc);
    exp_t e;
    e.name = nm;
    e.val  = {pl, plv, ce, dn, to, cc};
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] ps, input logic [8:0] in);
    reset    = r;
    start    = s;
    prog_sel = ps;
    instr    = in;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      act   = {pc_load, pc_load_val, core_en, done, timeout, cycle_count};
      n_total++;
      if (act === mon_e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got pl=%0b plv=%h ce=%0b done=%0b to=%0b cc=%0d, expected pl=%0b plv=%h ce=%0b done=%0b to=%0b cc=%0d",
                 mon_e.name, act[27], act[26:19], act[18], act[17], act[16], act[15:0],
                 mon_e.val[27], mon_e.val[26:19], mon_e.val[18], mon_e.val[17],
                 mon_e.val[16], mon_e.val[15:0]);
      end
      n_total++;
      if (!(pc_load === 1'b1 && core_en === 1'b1)) begin
        n_pass++;
      end else begin
        $display("FAIL %s_excl: got pc_load=%0b core_en=%0b, expected not both 1",
                 mon_e.name, pc_load, core_en);
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 2'd0, 9'h000);
    tick;
    tick;

    // Load slot 2, holding start for three cycles; later prog_sel changes ignored.
    drive(1'b0, 1'b1, 2'd2, 9'h000); expect_out("reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b1, 2'd2, 9'h000); expect_out("load1", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b1, 2'd3, 9'h000); expect_out("load2_selhold", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b0, 2'd3, 9'h000); expect_out("load3", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd0); tick;

    // Halt on the 10th RUN cycle.
    for (int unsigned i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b0, 2'd3, 9'(i));
      expect_out("run_count", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 16'(i - 1));
      tick;
    end
    drive(1'b0, 1'b0, 2'd3, 9'h1FF); expect_out("run_halt", 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 16'd9); tick;
    drive(1'b0, 1'b0, 2'd3, 9'h000); expect_out("done_halt", 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 16'd10); tick;
    drive(1'b0, 1'b0, 2'd3, 9'h1FF); expect_out("done_hold", 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 16'd10); tick;
    drive(1'b0, 1'b1, 2'd3, 9'h000); expect_out("done_to_load", 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 16'd10); tick;

    // Watchdog: 16 non-halt RUN cycles.
    drive(1'b0, 1'b0, 2'd0, 9'h000); expect_out("load_sel3", 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    for (int unsigned i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 2'd0, 9'h055);
      expect_out("run_wdog", 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 16'(i - 1));
      tick;
    end
    drive(1'b0, 1'b0, 2'd0, 9'h000); expect_out("done_timeout", 1'b0, 8'hC0, 1'b0, 1'b1, 1'b1, 16'd16); tick;
    drive(1'b0, 1'b0, 2'd0, 9'h000); expect_out("done_timeout_hold", 1'b0, 8'hC0, 1'b0, 1'b1, 1'b1, 16'd16); tick;
    drive(1'b0, 1'b1, 2'd0, 9'h000); expect_out("done_restart", 1'b0, 8'hC0, 1'b0, 1'b1, 1'b1, 16'd16); tick;

    // Abort on RUN cycle 5 (with halt present) selecting slot 1.
    drive(1'b0, 1'b0, 2'd0, 9'h000); expect_out("load_sel0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 2'd0, 9'h011);
      expect_out("run_pre_abort", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'(i - 1));
      tick;
    end
    drive(1'b0, 1'b1, 2'd1, 9'h1FF); expect_out("run_abort", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd4); tick;
    drive(1'b0, 1'b0, 2'd2, 9'h000); expect_out("abort_load", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 16'd0); tick;

    // Halt lands on the watchdog cycle: halt wins.
    for (int unsigned i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b0, 2'd2, 9'h022);
      expect_out("run_pre_halt", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'(i - 1));
      tick;
    end
    drive(1'b0, 1'b0, 2'd2, 9'h1FF); expect_out("halt_at_timeout", 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 16'd15); tick;
    drive(1'b0, 1'b0, 2'd2, 9'h000); expect_out("done_halt_wins", 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 16'd16); tick;

    // Reset in DONE (start high), then in RUN.
    drive(1'b1, 1'b1, 2'd2, 9'h000); expect_out("done_reset", 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 16'd16); tick;
    drive(1'b0, 1'b0, 2'd2, 9'h000); expect_out("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b1, 2'd2, 9'h000); expect_out("idle_start", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b0, 2'd1, 9'h000); expect_out("load_after_reset", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    for (int unsigned i = 1; i <= 2; i++) begin
      drive(1'b0, 1'b0, 2'd1, 9'h033);
      expect_out("run_pre_reset", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 16'(i - 1));
      tick;
    end
    drive(1'b1, 1'b0, 2'd1, 9'h033); expect_out("run_reset", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 16'd2); tick;
    drive(1'b0, 1'b1, 2'd1, 9'h000); expect_out("run_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0); tick;
    drive(1'b0, 1'b0, 2'd1, 9'h000); expect_out("load_after_run_reset", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 16'd0); tick;

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter HALT_WORD, default 9'h1FF, instruction encoding that ends a program run.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd4096, maximum RUN cycles before a forced stop.
REQ-003 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  level request from bench; high = load/hold program entry, falling edge = begin run.
REQ-006 Port prog_sel  input  2  program slot index, sampled on first start cycle.
REQ-007 Port instr  input  9  current instruction word fetched at the core's PC.
REQ-008 Port pc_load  output  1  forces the core PC to pc_load_val on the next clock.
REQ-009 Port pc_load_val  output  8  program base address for the selected slot.
REQ-010 Port core_en  output  1  enables PC update and register/memory writes in the core.
REQ-011 Port done  output  1  program finished; held until next start.
REQ-012 Port timeout  output  1  set with done when the run ended by watchdog, not by HALT_WORD.
REQ-013 Port cycle_count  output  16  RUN-cycle count of the current or last run.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE; state register is the only source of Moore outputs.
REQ-015 IDLE: core_en=0, done=0, pc_load=0; start=1 -> LOAD.
REQ-016 On IDLE->LOAD or DONE->LOAD or RUN->LOAD, prog_sel latched into sel_q; later prog_sel changes ignored until the next entry into LOAD.
REQ-017 LOAD: pc_load=1, pc_load_val=PROG_BASE[sel_q], core_en=0, cycle_count cleared to 0, done=0, timeout=0; stay while start=1.
REQ-018 LOAD with start=0 -> RUN; minimum LOAD dwell 1 cycle.
REQ-019 RUN: core_en = (instr != HALT_WORD), combinational, so the halt instruction never commits or advances the PC.
REQ-020 RUN: cycle_count increments by 1 every cycle, saturating at 16'hFFFF.
REQ-021 RUN with instr == HALT_WORD -> DONE, timeout stays 0.
REQ-022 RUN with cycle_count == TIMEOUT_CYCLES-1 and instr != HALT_WORD -> DONE, timeout set to 1.
REQ-023 HALT_WORD and timeout condition in the same cycle: halt wins, timeout=0.
REQ-024 RUN with start=1 (abort) -> LOAD; abort takes priority over halt and timeout.
REQ-025 DONE: done=1, core_en=0, pc_load=0, cycle_count and timeout frozen; start=1 -> LOAD.
REQ-026 pc_load and core_en never both 1 in the same cycle.
REQ-027 pc_load_val outside LOAD equals PROG_BASE[sel_q] (stable, don't-care to the core).

Reset
REQ-028 reset=1 at posedge clk forces state IDLE, sel_q=0, cycle_count=0, done=0, timeout=0, pc_load=0, core_en=0, regardless of current state or start.
REQ-029 reset overrides all transitions, including mid-RUN and in DONE; first post-reset cycle behaves as IDLE.

Structure
REQ-030 Shared package core_seq_pkg holds the state enum (IDLE, LOAD, RUN, DONE) and constant PROG_BASE[4] = 8'h00, 8'h40, 8'h80, 8'hC0.
REQ-031 Single sub-module sat_counter16 (sync clear, enable, saturate at 16'hFFFF) implements cycle_count; FSM and output decode stay in core_sequencer.

Verification
REQ-032 reset, start=1 with prog_sel=2 for 3 cycles, then 0 -> pc_load=1, pc_load_val=8'h80 for 3 cycles, then core_en=1, cycle_count counts 1,2,3...
REQ-033 RUN, instr=9'h1FF on 10th RUN cycle -> core_en=0 that cycle, next cycle done=1, timeout=0, cycle_count=10, held until start.
REQ-034 RUN with instr never HALT_WORD, TIMEOUT_CYCLES=16 -> done=1, timeout=1 after 16 RUN cycles, cycle_count=16.
REQ-035 start=1 in RUN on cycle 5 with prog_sel=1 -> next cycle LOAD, pc_load_val=8'h40, cycle_count=0, core_en=0.
REQ-036 reset=1 during RUN and during DONE -> next cycle all outputs 0, state IDLE; start=1 afterwards -> LOAD with pc_load_val=PROG_BASE[prog_sel].
REQ-037 HALT_WORD on the timeout cycle (TIMEOUT_CYCLES=16, halt on 16th RUN cycle) -> done=1, timeout=0.
